// File: rtl/byte_decryptor.sv
// Multi-round byte decryptor: per round rotate right by key[2:0], then XOR with the key.
// Optional running checksum of delivered bytes is enabled by defining DEC_CHECKSUM_EN.
module byte_decryptor #(
   parameter int ROUNDS = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] cipher_in,
   input  logic [7:0] key,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] plain_out,
   output logic       busy,
   output logic [7:0] checksum
);

   typedef enum logic [1:0] {IDLE, ROT, MIX, HOLD} state_t;

   localparam logic [1:0] LAST_ROUND = 2'(ROUNDS - 1);

   state_t     state, state_n;
   logic [7:0] data, data_n;
   logic [7:0] key_reg, key_reg_n;
   logic [2:0] rot_cnt, rot_cnt_n;
   logic [1:0] round_cnt, round_cnt_n;

   // State and datapath registers; reset aborts any byte in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         data      <= 8'h00;
         key_reg   <= 8'h00;
         rot_cnt   <= 3'd0;
         round_cnt <= 2'd0;
      end else begin
         state     <= state_n;
         data      <= data_n;
         key_reg   <= key_reg_n;
         rot_cnt   <= rot_cnt_n;
         round_cnt <= round_cnt_n;
      end
   end

   // Next-state logic: ROT spends one cycle per bit of rotation, MIX applies the key once per round.
   always_comb begin
      state_n     = state;
      data_n      = data;
      key_reg_n   = key_reg;
      rot_cnt_n   = rot_cnt;
      round_cnt_n = round_cnt;
      case (state)
         IDLE: begin
            if (in_valid) begin
               data_n      = cipher_in;
               key_reg_n   = key;
               round_cnt_n = 2'd0;
               rot_cnt_n   = key[2:0];
               state_n     = (key[2:0] != 3'd0) ? ROT : MIX;
            end
         end
         ROT: begin
            data_n    = {data[0], data[7:1]};
            rot_cnt_n = rot_cnt - 3'd1;
            if (rot_cnt == 3'd1) begin
               state_n = MIX;
            end
         end
         MIX: begin
            data_n = data ^ key_reg;
            if (round_cnt == LAST_ROUND) begin
               state_n = HOLD;
            end else begin
               round_cnt_n = round_cnt + 2'd1;
               rot_cnt_n   = key_reg[2:0];
               state_n     = (key_reg[2:0] != 3'd0) ? ROT : MIX;
            end
         end
         HOLD: begin
            if (out_ready) begin
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign in_ready  = (state == IDLE);
   assign busy      = (state != IDLE);
   assign out_valid = (state == HOLD);
   assign plain_out = out_valid ? data : 8'h00;

`ifdef DEC_CHECKSUM_EN
   logic [7:0] checksum_reg;

   // Folds each byte into the checksum on the cycle it is handed off downstream.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         checksum_reg <= 8'h00;
      end else if (out_valid && out_ready) begin
         checksum_reg <= checksum_reg ^ plain_out;
      end
   end

   assign checksum = checksum_reg;
`else
   assign checksum = 8'h00;
`endif

endmodule

// File: tb/tb_byte_decryptor.sv
// Scoreboard bench for byte_decryptor (ROUNDS=1): stimulus pushes expected bytes and
// output-rise cycles, a negedge monitor pops and compares them when out_valid rises.
module tb_byte_decryptor;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] cipher_in;
   logic [7:0] key;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] plain_out;
   logic       busy;
   logic [7:0] checksum;

   typedef struct {
      logic [7:0]  data;
      int unsigned riseCycle;
   } exp_t;

   exp_t        sbQueue[$];
   int          checks = 0;
   int          failures = 0;
   int unsigned cycleCount = 0;
   logic        prevValid = 1'b0;
   logic [7:0]  modelChecksum = 8'h00;

   byte_decryptor #(.ROUNDS(1)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .cipher_in (cipher_in),
      .key       (key),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .plain_out (plain_out),
      .busy      (busy),
      .checksum  (checksum)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cycleCount <= cycleCount + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
      checks++;
      if (actual !== required) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, expected %0h at cycle %0d", name, actual, required, cycleCount);
      end
   endtask

   // Waits for in_ready, issues one byte, and optionally records its expected result and rise cycle.
   task automatic applyStimulus(input logic [7:0] c, input logic [7:0] k, input logic [7:0] expected,
                                input int unsigned latency, input bit track);
      int waited;
      exp_t e;
      waited = 0;
      while (!in_ready && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      if (!in_ready) checkOutput("in_ready timeout", 0, 1);
      in_valid  = 1'b1;
      cipher_in = c;
      key       = k;
      @(negedge clk);
      in_valid = 1'b0;
      if (track) begin
         e.data      = expected;
         e.riseCycle = cycleCount + latency;
         sbQueue.push_back(e);
      end
   endtask

   task automatic waitDrained();
      int waited;
      waited = 0;
      while (!(sbQueue.size() == 0 && in_ready && !out_valid) && waited < 300) begin
         @(negedge clk);
         waited++;
      end
      if (waited >= 300) checkOutput("drain timeout", 0, 1);
   endtask

   // Monitor: every out_valid rise must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst) begin
         prevValid = 1'b0;
      end else begin
         if (out_valid && !prevValid) begin
            if (sbQueue.size() == 0) begin
               checkOutput("unexpected out_valid", 1, 0);
            end else begin
               exp_t e;
               e = sbQueue.pop_front();
               checkOutput("plain_out", 32'(plain_out), 32'(e.data));
               checkOutput("latency cycle", cycleCount, e.riseCycle);
            end
         end
         if (!out_valid) checkOutput("plain_out idle zero", 32'(plain_out), 0);
         prevValid = out_valid;
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      cipher_in = 8'h00;
      key       = 8'h00;
      out_ready = 1'b1;
      #1;
      checkOutput("reset out_valid", 32'(out_valid), 0);
      checkOutput("reset busy", 32'(busy), 0);
      checkOutput("reset in_ready", 32'(in_ready), 1);
      checkOutput("reset plain_out", 32'(plain_out), 0);
      checkOutput("reset checksum", 32'(checksum), 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      applyStimulus(8'h01, 8'h03, 8'h23, 4, 1);
      waitDrained();
      modelChecksum ^= 8'h23;

      applyStimulus(8'h80, 8'h07, 8'h06, 8, 1);
      repeat (2) begin
         in_valid  = 1'b1;
         cipher_in = 8'hFF;
         key       = 8'h01;
         @(negedge clk);
         in_valid = 1'b0;
         @(negedge clk);
      end
      waitDrained();
      modelChecksum ^= 8'h06;
`ifdef DEC_CHECKSUM_EN
      checkOutput("checksum two bytes", 32'(checksum), 32'h25);
`else
      checkOutput("checksum two bytes", 32'(checksum), 32'h00);
`endif

      applyStimulus(8'hA5, 8'h00, 8'hA5, 1, 1);
      waitDrained();
      modelChecksum ^= 8'hA5;

      // Backpressure: result must sit unchanged in HOLD until out_ready returns.
      out_ready = 1'b0;
      applyStimulus(8'h01, 8'h03, 8'h23, 4, 1);
      for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         checkOutput("hold out_valid", 32'(out_valid), 1);
         checkOutput("hold plain_out", 32'(plain_out), 32'h23);
         checkOutput("hold busy", 32'(busy), 1);
         checkOutput("hold in_ready", 32'(in_ready), 0);
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      checkOutput("release out_valid", 32'(out_valid), 0);
      checkOutput("release in_ready", 32'(in_ready), 1);
      modelChecksum ^= 8'h23;

      // Reset mid-ROT aborts the byte without any output.
      applyStimulus(8'h55, 8'h07, 8'h00, 8, 0);
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checkOutput("abort out_valid", 32'(out_valid), 0);
      checkOutput("abort busy", 32'(busy), 0);
      checkOutput("abort in_ready", 32'(in_ready), 1);
      checkOutput("abort checksum", 32'(checksum), 0);
      modelChecksum = 8'h00;
      @(negedge clk);
      rst = 1'b0;

      applyStimulus(8'h3C, 8'h05, 8'hE4, 6, 1);
      waitDrained();
      modelChecksum ^= 8'hE4;
      applyStimulus(8'hF0, 8'h92, 8'hAE, 3, 1);
      waitDrained();
      modelChecksum ^= 8'hAE;
`ifdef DEC_CHECKSUM_EN
      checkOutput("checksum after reset", 32'(checksum), 32'(modelChecksum));
`else
      checkOutput("checksum after reset", 32'(checksum), 32'h00);
`endif
      checkOutput("scoreboard empty", sbQueue.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/byte_decryptor.md
BYTE_DECRYPTOR -- requirements
Module: byte_decryptor

Interface
REQ-001 Parameter: ROUNDS, default 1, number of decrypt rounds; legal range 1..4.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: in_valid  input  1  cipher_in/key valid this cycle.
REQ-005 Port: in_ready  output  1  block can accept a byte; high only in IDLE.
REQ-006 Port: cipher_in  input  8  ciphertext byte.
REQ-007 Port: key  input  8  key byte; key[2:0] is the rotate count k.
REQ-008 Port: out_valid  output  1  plain_out holds a finished result.
REQ-009 Port: out_ready  input  1  downstream accepts plain_out.
REQ-010 Port: plain_out  output  8  decrypted byte.
REQ-011 Port: busy  output  1  high in every state except IDLE.
REQ-012 Port: checksum  output  8  running XOR of delivered plaintext bytes (see REQ-027/028).

Function
REQ-013 Decrypt is the inverse of the encrypt round "XOR key, then rotate left k"; each decrypt round SHALL rotate right by k, then XOR with the full 8-bit key.
REQ-014 The FSM SHALL have exactly four states: IDLE, ROT, MIX, HOLD.
REQ-015 IDLE: on in_valid=1, the block SHALL capture cipher_in into a data register and key into key_reg, and clear the round counter.
  - It SHALL load the rotate counter with k.
  - It SHALL go to ROT if k!=0, else MIX.
REQ-016 ROT: each cycle, data SHALL become {data[0],data[7:1]} and the rotate counter SHALL decrement; on the cycle it reaches 0, the FSM SHALL go to MIX.
REQ-017 MIX: data SHALL become data^key_reg for one cycle.
  - If this is the last round (round counter = ROUNDS-1), the FSM SHALL go to HOLD.
  - Otherwise it SHALL increment the round counter, reload the rotate counter with key_reg[2:0], and go to ROT (or MIX if k=0).
REQ-018 HOLD: out_valid SHALL be 1 and plain_out SHALL equal data.
  - On out_ready=1, the FSM SHALL go to IDLE.
  - While out_ready=0, plain_out SHALL stay stable.
REQ-019 Latency: out_valid SHALL rise exactly ROUNDS*(k+1) rising edges after the accepting edge.
REQ-020 in_ready SHALL be decoded from state (IDLE) only, with no combinational path from in_valid or out_ready.
REQ-021 in_valid outside IDLE SHALL be ignored; cipher_in and key changes after capture SHALL NOT affect the result.
REQ-022 The HOLD->IDLE handshake cycle SHALL NOT accept new input; back-to-back throughput is one byte per ROUNDS*(k+1)+2 cycles.
REQ-023 plain_out SHALL be 8'h00 whenever out_valid=0.

Reset
REQ-024 While rst=1, regardless of clk, the block SHALL force: state=IDLE, data, key_reg, both counters and checksum = 0.
REQ-025 Output values during reset SHALL be: out_valid=0, busy=0, in_ready=1, plain_out=8'h00.
REQ-026 Reset asserted mid-operation (ROT, MIX or HOLD) SHALL abort the byte with no output; the first edge after release SHALL behave as IDLE.

Configuration
REQ-027 With macro DEC_CHECKSUM_EN defined, checksum SHALL update to checksum^plain_out on every edge where out_valid=1 and out_ready=1.
REQ-028 Without DEC_CHECKSUM_EN, checksum SHALL be constant 8'h00, no checksum register SHALL be synthesized, and all other behaviour SHALL be identical.

Verification
REQ-029 ROUNDS=1, key=8'h03, cipher_in=8'h01, out_ready=1 -> plain_out=8'h23; out_valid 4 edges after accept, high 1 cycle.
REQ-030 ROUNDS=1, key=8'h00, cipher_in=8'hA5 -> plain_out=8'hA5 with latency 1 (IDLE->MIX->HOLD).
REQ-031 ROUNDS=1, key=8'h07, cipher_in=8'h80 -> plain_out=8'h06 with latency 8; in_valid pulses with other data during ROT have no effect.
REQ-032 Backpressure: hold out_ready=0 for 5 cycles in HOLD -> out_valid, plain_out and busy stay constant, in_ready=0; release -> IDLE next edge.
REQ-033 Reset in ROT (key=8'h07, 3 cycles after accept) -> immediate out_valid=0, busy=0, in_ready=1; a subsequent byte decrypts correctly.
REQ-034 DEC_CHECKSUM_EN defined, bytes from REQ-029 then REQ-031 delivered -> checksum=8'h25; without the macro -> checksum=8'h00.
